apb_arb2: RTL and testbench
===========================

APB_ARB2 -- requirements
Module: apb_arb2

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width; STRB_W = DATA_W/8.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset, as follows:
- pclk_i  in  1  clock; all state changes on rising edge.
- preset_n  in  1  asynchronous active-low reset.
REQ-004 The block SHALL provide requester ports for N = 0,1:
- sN_paddr_i  in  ADDR_W  requester address.
- sN_pwdata_i  in  DATA_W  write data.
- sN_pwrite_i  in  1  1 = write.
- sN_psel_i  in  1  requester select.
- sN_penable_i  in  1  requester access phase.
- sN_pstrb_i  in  STRB_W  write byte strobes.
- sN_prdata_o  out  DATA_W  read data.
- sN_pready_o  out  1  transfer complete.
- sN_pslverr_o  out  1  transfer error.
REQ-005 The block SHALL provide the completer port:
- m_paddr_o, m_pwdata_o, m_pwrite_o, m_pstrb_o  out  ADDR_W/DATA_W/1/STRB_W  forwarded request.
- m_psel_o, m_penable_o  out  1  downstream APB phase control.
- m_prdata_i  in  DATA_W, m_pready_i  in  1, m_pslverr_i  in  1  downstream response.
- grant_o  out  2  one-hot owner of the current transfer; 0 when idle.

Function
REQ-006 The FSM SHALL have states IDLE, SETUP, ACCESS.
REQ-007 In IDLE, a requester SHALL be pending when sN_psel_i = 1; with no pending requester the FSM SHALL stay in IDLE.
REQ-008 In IDLE with one pending requester, the block SHALL grant it, latch grant, and go to SETUP next cycle.
REQ-009 In IDLE with both pending, the block SHALL grant the requester indicated by the round-robin pointer rr (reset 0).
REQ-010 After each completed downstream transfer, rr SHALL point to the requester that was not granted.
REQ-011 In SETUP, the block SHALL drive m_psel_o=1 and m_penable_o=0, and SHALL go to ACCESS unconditionally.
REQ-012 In ACCESS, the block SHALL drive m_psel_o=1 and m_penable_o=1; it SHALL stay until m_pready_i=1, then return to IDLE.
REQ-013 The ACCESS-to-IDLE transition SHALL NOT re-arbitrate in the same cycle, so there is at least one idle cycle between transfers.
REQ-014 m_paddr_o, m_pwdata_o, m_pwrite_o and m_pstrb_o SHALL come from registers loaded from the granted requester on the IDLE->SETUP edge, and SHALL be held constant through ACCESS.
REQ-015 sN_pready_o SHALL equal m_pready_i only when state = ACCESS and grant_o[N] = 1; otherwise it SHALL be 0.
REQ-016 sN_pslverr_o SHALL equal m_pslverr_i gated like sN_pready_o.
REQ-017 sN_prdata_o SHALL equal m_prdata_i when sN_pready_o = 1, else 0.
REQ-018 The non-granted requester SHALL see pready=0 and SHALL be serviced after the current transfer, in arbitration order.
REQ-019 Minimum latency from sN_psel_i rising in IDLE to sN_pready_o SHALL be 3 cycles (IDLE, SETUP, ACCESS with m_pready_i=1).
REQ-020 If the granted requester drops psel mid-transfer, the downstream transfer SHALL still complete, and the response SHALL be discarded (pready to that requester still pulses, ignored).
REQ-021 grant_o SHALL be nonzero exactly in SETUP and ACCESS.

Reset
REQ-022 While preset_n = 0, the block SHALL hold state IDLE, rr = 0, grant_o = 0, m_psel_o = 0, m_penable_o = 0, request registers = 0, and all sN_pready_o, sN_pslverr_o and sN_prdata_o = 0.
REQ-023 Reset asserted mid-transfer SHALL abort immediately to the reset values, with no response returned.

Verification
REQ-024 s0 write, addr 0x10, data 0xA5A5A5A5, strb 0xF, m_pready_i tied 1 -> m_psel_o at cycle+1, m_penable_o at cycle+2, s0_pready_o=1 at cycle+2, s1_pready_o stays 0.
REQ-025 s0 and s1 both request from reset -> s0 served first, then s1; repeat with both held -> order s0, s1, s0, s1.
REQ-026 s1 read, m_pready_i low 4 ACCESS cycles, m_prdata_i=0x12345678 -> m_paddr_o stable, s1_prdata_o=0x12345678 only in the pready cycle.
REQ-027 m_pslverr_i=1 with pready on an s0 transfer -> s0_pslverr_o=1 for one cycle, s1_pslverr_o=0.
REQ-028 preset_n pulled low during ACCESS -> m_psel_o=0, grant_o=0 immediately; after release, a pending s1 request is granted only after s0 priority is re-evaluated (rr=0).

Source files
------------

// File: rtl/apb_arb2_if.sv
// Bus bundle for the two-requester APB arbiter: two requester ports plus one completer port.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface apb_arb2_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] s0_paddr_i;
    logic [DATA_W-1:0] s0_pwdata_i;
    logic              s0_pwrite_i;
    logic              s0_psel_i;
    logic              s0_penable_i;
    logic [STRB_W-1:0] s0_pstrb_i;
    logic [DATA_W-1:0] s0_prdata_o;
    logic              s0_pready_o;
    logic              s0_pslverr_o;

    logic [ADDR_W-1:0] s1_paddr_i;
    logic [DATA_W-1:0] s1_pwdata_i;
    logic              s1_pwrite_i;
    logic              s1_psel_i;
    logic              s1_penable_i;
    logic [STRB_W-1:0] s1_pstrb_i;
    logic [DATA_W-1:0] s1_prdata_o;
    logic              s1_pready_o;
    logic              s1_pslverr_o;

    logic [ADDR_W-1:0] m_paddr_o;
    logic [DATA_W-1:0] m_pwdata_o;
    logic              m_pwrite_o;
    logic [STRB_W-1:0] m_pstrb_o;
    logic              m_psel_o;
    logic              m_penable_o;
    logic [DATA_W-1:0] m_prdata_i;
    logic              m_pready_i;
    logic              m_pslverr_i;
    logic [1:0]        grant_o;

    modport slave (
        input  s0_paddr_i, s0_pwdata_i, s0_pwrite_i, s0_psel_i, s0_penable_i, s0_pstrb_i,
        input  s1_paddr_i, s1_pwdata_i, s1_pwrite_i, s1_psel_i, s1_penable_i, s1_pstrb_i,
        input  m_prdata_i, m_pready_i, m_pslverr_i,
        output s0_prdata_o, s0_pready_o, s0_pslverr_o,
        output s1_prdata_o, s1_pready_o, s1_pslverr_o,
        output m_paddr_o, m_pwdata_o, m_pwrite_o, m_pstrb_o, m_psel_o, m_penable_o, grant_o
    );

    modport master (
        output s0_paddr_i, s0_pwdata_i, s0_pwrite_i, s0_psel_i, s0_penable_i, s0_pstrb_i,
        output s1_paddr_i, s1_pwdata_i, s1_pwrite_i, s1_psel_i, s1_penable_i, s1_pstrb_i,
        output m_prdata_i, m_pready_i, m_pslverr_i,
        input  s0_prdata_o, s0_pready_o, s0_pslverr_o,
        input  s1_prdata_o, s1_pready_o, s1_pslverr_o,
        input  m_paddr_o, m_pwdata_o, m_pwrite_o, m_pstrb_o, m_psel_o, m_penable_o, grant_o
    );
endinterface

// File: rtl/apb_arb2.sv
// Two-requester APB arbiter: round-robin grant in IDLE, one downstream SETUP/ACCESS
// transfer per grant, response steered back only to the owner of the transfer.
module apb_arb2 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic       pclk_i,
    input  logic       preset_n,
    apb_arb2_if.slave  bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e            state_r;
    state_e            state_next_s;
    logic [1:0]        grant_r;
    logic [1:0]        grant_next_s;
    logic              rr_r;
    logic              rr_next_s;
    logic              load_s;
    logic              m_psel_r;
    logic              m_penable_r;

    logic [ADDR_W-1:0] paddr_r;
    logic [DATA_W-1:0] pwdata_r;
    logic              pwrite_r;
    logic [STRB_W-1:0] pstrb_r;
    logic [ADDR_W-1:0] paddr_sel_s;
    logic [DATA_W-1:0] pwdata_sel_s;
    logic              pwrite_sel_s;
    logic [STRB_W-1:0] pstrb_sel_s;

    logic              access_s;
    logic              s0_pready_s;
    logic              s1_pready_s;
    logic              s0_pslverr_s;
    logic              s1_pslverr_s;
    logic              unused_penable_s;

    // Requester access-phase strobes carry no information the arbiter needs.
    assign unused_penable_s = bus.s0_penable_i ^ bus.s1_penable_i;

    // Next-state, next-grant and round-robin pointer update.
    always_comb begin
        state_next_s = state_r;
        grant_next_s = grant_r;
        rr_next_s    = rr_r;
        load_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.s0_psel_i && bus.s1_psel_i) begin
                    grant_next_s = rr_r ? 2'b10 : 2'b01;
                    state_next_s = ST_SETUP;
                    load_s       = 1'b1;
                end else if (bus.s0_psel_i) begin
                    grant_next_s = 2'b01;
                    state_next_s = ST_SETUP;
                    load_s       = 1'b1;
                end else if (bus.s1_psel_i) begin
                    grant_next_s = 2'b10;
                    state_next_s = ST_SETUP;
                    load_s       = 1'b1;
                end else begin
                    grant_next_s = 2'b00;
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_next_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.m_pready_i) begin
                    // Going back through IDLE forces one idle cycle before the next grant.
                    state_next_s = ST_IDLE;
                    grant_next_s = 2'b00;
                    rr_next_s    = grant_r[0];
                end else begin
                    state_next_s = ST_ACCESS;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                grant_next_s = 2'b00;
            end
        endcase
    end

    // Request fields of whichever requester is about to be granted.
    always_comb begin
        if (grant_next_s[1]) begin
            paddr_sel_s  = bus.s1_paddr_i;
            pwdata_sel_s = bus.s1_pwdata_i;
            pwrite_sel_s = bus.s1_pwrite_i;
            pstrb_sel_s  = bus.s1_pstrb_i;
        end else begin
            paddr_sel_s  = bus.s0_paddr_i;
            pwdata_sel_s = bus.s0_pwdata_i;
            pwrite_sel_s = bus.s0_pwrite_i;
            pstrb_sel_s  = bus.s0_pstrb_i;
        end
    end

    // FSM state, grant, pointer and downstream phase controls.
    always_ff @(posedge pclk_i or negedge preset_n) begin
        if (!preset_n) begin
            state_r     <= ST_IDLE;
            grant_r     <= 2'b00;
            rr_r        <= 1'b0;
            m_psel_r    <= 1'b0;
            m_penable_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            grant_r     <= grant_next_s;
            rr_r        <= rr_next_s;
            m_psel_r    <= (state_next_s != ST_IDLE);
            m_penable_r <= (state_next_s == ST_ACCESS);
        end
    end

    // Forwarded request, captured once on the grant edge and frozen for the transfer.
    always_ff @(posedge pclk_i or negedge preset_n) begin
        if (!preset_n) begin
            paddr_r  <= {ADDR_W{1'b0}};
            pwdata_r <= {DATA_W{1'b0}};
            pwrite_r <= 1'b0;
            pstrb_r  <= {STRB_W{1'b0}};
        end else if (load_s) begin
            paddr_r  <= paddr_sel_s;
            pwdata_r <= pwdata_sel_s;
            pwrite_r <= pwrite_sel_s;
            pstrb_r  <= pstrb_sel_s;
        end else begin
            paddr_r  <= paddr_r;
            pwdata_r <= pwdata_r;
            pwrite_r <= pwrite_r;
            pstrb_r  <= pstrb_r;
        end
    end

    // The completer response is passed through in the same cycle, so it is
    // gated from registered state rather than re-registered.
    assign access_s     = (state_r == ST_ACCESS);
    assign s0_pready_s  = access_s & grant_r[0] & bus.m_pready_i;
    assign s1_pready_s  = access_s & grant_r[1] & bus.m_pready_i;
    assign s0_pslverr_s = access_s & grant_r[0] & bus.m_pslverr_i;
    assign s1_pslverr_s = access_s & grant_r[1] & bus.m_pslverr_i;

    assign bus.s0_pready_o  = s0_pready_s;
    assign bus.s1_pready_o  = s1_pready_s;
    assign bus.s0_pslverr_o = s0_pslverr_s;
    assign bus.s1_pslverr_o = s1_pslverr_s;
    assign bus.s0_prdata_o  = s0_pready_s ? bus.m_prdata_i : {DATA_W{1'b0}};
    assign bus.s1_prdata_o  = s1_pready_s ? bus.m_prdata_i : {DATA_W{1'b0}};

    assign bus.m_paddr_o   = paddr_r;
    assign bus.m_pwdata_o  = pwdata_r;
    assign bus.m_pwrite_o  = pwrite_r;
    assign bus.m_pstrb_o   = pstrb_r;
    assign bus.m_psel_o    = m_psel_r;
    assign bus.m_penable_o = m_penable_r;
    assign bus.grant_o     = grant_r;
endmodule

// File: tb/tb_apb_arb2.sv
// Directed bench for apb_arb2: a per-cycle vector table followed by hand-written
// sequences for back-to-back arbitration and reset in the middle of a transfer.
module tb_apb_arb2;
    localparam logic [31:0] Z32 = 32'h0000_0000;
    localparam logic [31:0] CF  = 32'hCAFE_F00D;
    localparam logic [31:0] RD  = 32'h1234_5678;
    localparam logic [31:0] A5  = 32'hA5A5_A5A5;
    localparam logic [31:0] D3  = 32'h1122_3344;
    localparam logic [31:0] F1  = 32'hFFFF_FFFF;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    apb_arb2_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_arb2 #(.ADDR_W(32), .DATA_W(32)) dut (
        .pclk_i   (clk),
        .preset_n (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel0, sel1;
        logic [31:0] a0, a1, d0, d1;
        logic        w0, w1;
        logic [3:0]  st0, st1;
        logic        rdy;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  g;
        logic        ps, pe;
        logic [31:0] addr, wd;
        logic        wr;
        logic [3:0]  st;
        logic        rdy0, rdy1;
        logic [31:0] rd0, rd1;
        logic        err0, err1;
    } vec_t;

    vec_t tbl [25];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.s0_psel_i   = v.sel0;
        bus.s1_psel_i   = v.sel1;
        bus.s0_penable_i = 1'b0;
        bus.s1_penable_i = 1'b0;
        bus.s0_paddr_i  = v.a0;
        bus.s1_paddr_i  = v.a1;
        bus.s0_pwdata_i = v.d0;
        bus.s1_pwdata_i = v.d1;
        bus.s0_pwrite_i = v.w0;
        bus.s1_pwrite_i = v.w1;
        bus.s0_pstrb_i  = v.st0;
        bus.s1_pstrb_i  = v.st1;
        bus.m_pready_i  = v.rdy;
        bus.m_prdata_i  = v.rdata;
        bus.m_pslverr_i = v.err;
    endtask

    task automatic check_row(input int i, input vec_t v);
        chk($sformatf("row%0d grant", i),   {62'd0, bus.grant_o},     {62'd0, v.g});
        chk($sformatf("row%0d psel", i),    {63'd0, bus.m_psel_o},    {63'd0, v.ps});
        chk($sformatf("row%0d penable", i), {63'd0, bus.m_penable_o}, {63'd0, v.pe});
        chk($sformatf("row%0d paddr", i),   {32'd0, bus.m_paddr_o},   {32'd0, v.addr});
        chk($sformatf("row%0d pwdata", i),  {32'd0, bus.m_pwdata_o},  {32'd0, v.wd});
        chk($sformatf("row%0d pwrite", i),  {63'd0, bus.m_pwrite_o},  {63'd0, v.wr});
        chk($sformatf("row%0d pstrb", i),   {60'd0, bus.m_pstrb_o},   {60'd0, v.st});
        chk($sformatf("row%0d s0_pready", i),  {63'd0, bus.s0_pready_o},  {63'd0, v.rdy0});
        chk($sformatf("row%0d s1_pready", i),  {63'd0, bus.s1_pready_o},  {63'd0, v.rdy1});
        chk($sformatf("row%0d s0_prdata", i),  {32'd0, bus.s0_prdata_o},  {32'd0, v.rd0});
        chk($sformatf("row%0d s1_prdata", i),  {32'd0, bus.s1_prdata_o},  {32'd0, v.rd1});
        chk($sformatf("row%0d s0_pslverr", i), {63'd0, bus.s0_pslverr_o}, {63'd0, v.err0});
        chk($sformatf("row%0d s1_pslverr", i), {63'd0, bus.s1_pslverr_o}, {63'd0, v.err1});
    endtask

    task automatic idle_inputs();
        vec_t v;
        v = tbl[0];
        apply(v);
    endtask

    initial begin
        logic [1:0] exp_g;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;

        // sel0 sel1 a0 a1 d0 d1 w0 w1 st0 st1 rdy rdata err | g ps pe addr wd wr st rdy0 rdy1 rd0 rd1 err0 err1
        tbl[0]  = '{1'b0,1'b0, Z32,Z32, Z32,Z32, 1'b0,1'b0, 4'h0,4'h0, 1'b0,CF,1'b0, 2'b00,1'b0,1'b0, Z32,Z32,1'b0,4'h0, 1'b0,1'b0,Z32,Z32,1'b0,1'b0};
        // s0 write 0x10, completer always ready
        tbl[1]  = '{1'b1,1'b0, 32'h10,Z32, A5,Z32, 1'b1,1'b0, 4'hF,4'h0, 1'b1,CF,1'b0, 2'b00,1'b0,1'b0, Z32,Z32,1'b0,4'h0, 1'b0,1'b0,Z32,Z32,1'b0,1'b0};
        tbl[2]  = '{1'b1,1'b0, 32'h10,Z32, A5,Z32, 1'b1,1'b0, 4'hF,4'h0, 1'b1,CF,1'b0, 2'b01,1'b1,1'b0, 32'h10,A5,1'b1,4'hF, 1'b0,1'b0,Z32,Z32,1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b0, 32'h10,Z32, A5,Z32, 1'b1,1'b0, 4'hF,4'h0, 1'b1,CF,1'b0, 2'b01,1'b1,1'b1, 32'h10,A5,1'b1,4'hF, 1'b1,1'b0,CF,Z32,1'b0,1'b0};
        tbl[4]  = '{1'b0,1'b0, 32'h10,Z32, A5,Z32, 1'b1,1'b0, 4'hF,4'h0, 1'b1,CF,1'b0, 2'b00,1'b0,1'b0, 32'h10,A5,1'b1,4'hF, 1'b0,1'b0,Z32,Z32,1'b0,1'b0};
        // s1 read 0x44 with four wait states; s1 inputs change while the transfer is held
        tbl[5]  = '{1'b0,1'b1, 32'h10,32'h44, A5,Z32, 1'b1,1'b0, 4'hF,4'h0, 1'b0,RD,1'b0, 2'b00,1'b0,1'b0, 32'h10,A5,1'b1,4'hF, 1'b0,1'b0,Z32,Z32,1'b0,1'b0};
        tbl[6]  = '{1'b0,1'b1, 32'h10,32'h44, A5,Z32, 1'b1,1'b0, 4'hF,4'h0, 1'b0,RD,1'b0, 2'b10,1'b1,1'b0, 32'h44,Z32,1'b0,4'h0, 1'b0,1'b0,Z32,Z32,1'b0,1'b0};
        for (int i = 7; i <= 10; i++)
            tbl[i] = '{1'b0,1'b1, 32'h10,32'h99, A5,F1, 1'b1,1'b1, 4'hF,4'hF, 1'b0,RD,1'b0, 2'b10,1'b1,1'b1, 32'h44,Z32,1'b0,4'h0, 1'b0,1'b0,Z32,Z32,1'b0,1'b0};
        tbl[11] = '{1'b0,1'b1, 32'h10,32'h99, A5,F1, 1'b1,1'b1, 4'hF,4'hF, 1'b1,RD,1'b0, 2'b10,1'b1,1'b1, 32'h44,Z32,1'b0,4'h0, 1'b0,1'b1,Z32,RD,1'b0,1'b0};
        tbl[12] = '{1'b0,1'b0, 32'h10,32'h99, A5,F1, 1'b1,1'b1, 4'hF,4'hF, 1'b1,CF,1'b0, 2'b00,1'b0,1'b0, 32'h44,Z32,1'b0,4'h0, 1'b0,1'b0,Z32,Z32,1'b0,1'b0};
        // s0 write 0x20 ending in an error response
        tbl[13] = '{1'b1,1'b0, 32'h20,32'h99, D3,F1, 1'b1,1'b1, 4'h3,4'hF, 1'b1,CF,1'b0, 2'b00,1'b0,1'b0, 32'h44,Z32,1'b0,4'h0, 1'b0,1'b0,Z32,Z32,1'b0,1'b0};
        tbl[14] = '{1'b1,1'b0, 32'h20,32'h99, D3,F1, 1'b1,1'b1, 4'h3,4'hF, 1'b1,CF,1'b0, 2'b01,1'b1,1'b0, 32'h20,D3,1'b1,4'h3, 1'b0,1'b0,Z32,Z32,1'b0,1'b0};
        tbl[15] = '{1'b1,1'b0, 32'h20,32'h99, D3,F1, 1'b1,1'b1, 4'h3,4'hF, 1'b1,CF,1'b1, 2'b01,1'b1,1'b1, 32'h20,D3,1'b1,4'h3, 1'b1,1'b0,CF,Z32,1'b1,1'b0};
        tbl[16] = '{1'b0,1'b0, 32'h20,32'h99, D3,F1, 1'b1,1'b1, 4'h3,4'hF, 1'b1,CF,1'b1, 2'b00,1'b0,1'b0, 32'h20,D3,1'b1,4'h3, 1'b0,1'b0,Z32,Z32,1'b0,1'b0};
        // s1 drops psel right after being granted; transfer still completes
        tbl[17] = '{1'b0,1'b1, 32'h20,32'h30, D3,32'h55, 1'b1,1'b1, 4'h3,4'h1, 1'b1,CF,1'b0, 2'b00,1'b0,1'b0, 32'h20,D3,1'b1,4'h3, 1'b0,1'b0,Z32,Z32,1'b0,1'b0};
        tbl[18] = '{1'b0,1'b0, 32'h20,32'h30, D3,32'h55, 1'b1,1'b1, 4'h3,4'h1, 1'b1,CF,1'b0, 2'b10,1'b1,1'b0, 32'h30,32'h55,1'b1,4'h1, 1'b0,1'b0,Z32,Z32,1'b0,1'b0};
        tbl[19] = '{1'b0,1'b0, 32'h20,32'h30, D3,32'h55, 1'b1,1'b1, 4'h3,4'h1, 1'b1,CF,1'b0, 2'b10,1'b1,1'b1, 32'h30,32'h55,1'b1,4'h1, 1'b0,1'b1,Z32,CF,1'b0,1'b0};
        tbl[20] = '{1'b0,1'b0, 32'h20,32'h30, D3,32'h55, 1'b1,1'b1, 4'h3,4'h1, 1'b1,CF,1'b0, 2'b00,1'b0,1'b0, 32'h30,32'h55,1'b1,4'h1, 1'b0,1'b0,Z32,Z32,1'b0,1'b0};
        // s1 alone while the pointer favours s0: still granted at once
        tbl[21] = '{1'b0,1'b1, 32'h20,32'h50, D3,32'h66, 1'b1,1'b0, 4'h3,4'h0, 1'b1,CF,1'b0, 2'b00,1'b0,1'b0, 32'h30,32'h55,1'b1,4'h1, 1'b0,1'b0,Z32,Z32,1'b0,1'b0};
        tbl[22] = '{1'b0,1'b1, 32'h20,32'h50, D3,32'h66, 1'b1,1'b0, 4'h3,4'h0, 1'b1,CF,1'b0, 2'b10,1'b1,1'b0, 32'h50,32'h66,1'b0,4'h0, 1'b0,1'b0,Z32,Z32,1'b0,1'b0};
        tbl[23] = '{1'b0,1'b1, 32'h20,32'h50, D3,32'h66, 1'b1,1'b0, 4'h3,4'h0, 1'b1,CF,1'b0, 2'b10,1'b1,1'b1, 32'h50,32'h66,1'b0,4'h0, 1'b0,1'b1,Z32,CF,1'b0,1'b0};
        tbl[24] = '{1'b0,1'b0, 32'h20,32'h50, D3,32'h66, 1'b1,1'b0, 4'h3,4'h0, 1'b1,CF,1'b0, 2'b00,1'b0,1'b0, 32'h50,32'h66,1'b0,4'h0, 1'b0,1'b0,Z32,Z32,1'b0,1'b0};

        idle_inputs();
        repeat (3) @(negedge clk);
        #2;
        chk("reset grant", {62'd0, bus.grant_o}, 64'd0);
        chk("reset psel",  {63'd0, bus.m_psel_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            apply(tbl[i]);
            #2;
            check_row(i, tbl[i]);
            @(negedge clk);
        end

        // Both requesters held from reset: s0, s1, s0, s1 with an idle cycle between.
        rst_n = 1'b0;
        idle_inputs();
        bus.s0_psel_i  = 1'b1;
        bus.s1_psel_i  = 1'b1;
        bus.m_pready_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #2;
            if (c % 3 == 0)            exp_g = 2'b00;
            else if ((c / 3) % 2 == 0) exp_g = 2'b01;
            else                       exp_g = 2'b10;
            chk($sformatf("rr cyc%0d grant", c), {62'd0, bus.grant_o}, {62'd0, exp_g});
            @(negedge clk);
        end

        // Reset in ACCESS of an s1 transfer, after s0 had moved the pointer to s1.
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        bus.s0_psel_i  = 1'b1;
        bus.s0_paddr_i = 32'h70;
        bus.m_pready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.s0_psel_i  = 1'b0;
        @(negedge clk);
        bus.s1_psel_i  = 1'b1;
        bus.s1_paddr_i = 32'h80;
        bus.m_pready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("pre-reset grant", {62'd0, bus.grant_o}, 64'd2);
        chk("pre-reset penable", {63'd0, bus.m_penable_o}, 64'd1);
        bus.m_pready_i = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("abort psel",      {63'd0, bus.m_psel_o},    64'd0);
        chk("abort penable",   {63'd0, bus.m_penable_o}, 64'd0);
        chk("abort grant",     {62'd0, bus.grant_o},     64'd0);
        chk("abort s1_pready", {63'd0, bus.s1_pready_o}, 64'd0);
        chk("abort paddr",     {32'd0, bus.m_paddr_o},   64'd0);
        bus.s0_psel_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("post-reset idle grant", {62'd0, bus.grant_o}, 64'd0);
        @(negedge clk);
        #2;
        chk("post-reset s0 first", {62'd0, bus.grant_o}, 64'd1);
        chk("post-reset paddr",    {32'd0, bus.m_paddr_o}, 64'h70);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
